// File: rtl/fp_pkg.sv
// Shared FP writeback types: register-file geometry and the arbiter's "last winner" encoding.
package fp_pkg;

    localparam int FP_DATA_W = 32;
    localparam int FP_REG_N  = 32;
    localparam int FP_IDX_W  = $clog2(FP_REG_N);

    typedef logic [FP_IDX_W-1:0] fp_idx_t;

    typedef enum logic {
        WB_FPU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter for the FP write port; bit 0 = FPU, bit 1 = LSU.
module rr_arb2
    import fp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    wb_src_e last;

    // On conflict the side that did not win last time goes first.
    always_comb begin
        grant    = 2'b00;
        grant[0] = req[0] & (~req[1] | (last == WB_LSU));
        grant[1] = req[1] & (~req[0] | (last == WB_FPU));
    end

    // Resetting to LSU hands the first conflict to the FPU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= WB_LSU;
        else if (|grant)
            last <= grant[1] ? WB_LSU : WB_FPU;
    end

endmodule

// File: rtl/fp_wb_scheduler.sv
// FP writeback scheduler: arbitrates FPU/LSU onto the single register-file write port
// and keeps a per-register busy scoreboard for decode hazard stalls.
module fp_wb_scheduler
    import fp_pkg::*;
#(
    parameter  int DATA_W = FP_DATA_W,
    parameter  int REG_N  = FP_REG_N,
    localparam int IDX_W  = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic [IDX_W-1:0]  issue_rd,
    input  logic [IDX_W-1:0]  rs1_index,
    input  logic [IDX_W-1:0]  rs2_index,
    input  logic              rs1_used,
    input  logic              rs2_used,
    output logic              hazard,
    input  logic              fpu_req,
    input  logic [IDX_W-1:0]  fpu_rd,
    input  logic [DATA_W-1:0] fpu_data,
    output logic              fpu_grant,
    input  logic              lsu_req,
    input  logic [IDX_W-1:0]  lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_grant,
    output logic              wb_en,
    output logic [IDX_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data
);

    logic [REG_N-1:0] busy;
    logic [REG_N-1:0] set_mask;
    logic [REG_N-1:0] clr_mask;
    logic [1:0]       grant;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({lsu_req, fpu_req}),
        .grant (grant)
    );

    assign fpu_grant = grant[0];
    assign lsu_grant = grant[1];

    assign hazard = (rs1_used    && busy[rs1_index]) ||
                    (rs2_used    && busy[rs2_index]) ||
                    (issue_valid && busy[issue_rd]);

    assign set_mask = (issue_valid && !hazard) ? (REG_N'(1) << issue_rd) : '0;
    assign clr_mask = wb_en ? (REG_N'(1) << wb_rd) : '0;

    // Set is applied after clear so an issue landing on a committing register stays busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else if (flush)
            busy <= '0;
        else
            busy <= (busy & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            wb_en <= |grant;
            if (grant[0]) begin
                wb_rd   <= fpu_rd;
                wb_data <= fpu_data;
            end else if (grant[1]) begin
                wb_rd   <= lsu_rd;
                wb_data <= lsu_data;
            end
        end
    end

endmodule

// File: tb/tb_fp_wb_scheduler.sv
// Directed bench for fp_wb_scheduler: expected writebacks go into a queue that a
// negedge monitor drains whenever wb_en is seen.
module tb_fp_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_rd, rs1_index, rs2_index;
    logic        rs1_used, rs2_used;
    logic        hazard;
    logic        fpu_req, lsu_req;
    logic [4:0]  fpu_rd, lsu_rd;
    logic [31:0] fpu_data, lsu_data;
    logic        fpu_grant, lsu_grant;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t sbq[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    fp_wb_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1_index   (rs1_index),
        .rs2_index   (rs2_index),
        .rs1_used    (rs1_used),
        .rs2_used    (rs2_used),
        .hazard      (hazard),
        .fpu_req     (fpu_req),
        .fpu_rd      (fpu_rd),
        .fpu_data    (fpu_data),
        .fpu_grant   (fpu_grant),
        .lsu_req     (lsu_req),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_grant   (lsu_grant),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        wb_t e;
        e.rd   = rd;
        e.data = data;
        sbq.push_back(e);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every observed writeback must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && wb_en) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected actual=rd%0d/%h required=none", wb_rd, wb_data);
            end else begin
                wb_t e;
                e = sbq.pop_front();
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_rd = '0;
        rs1_index = '0; rs2_index = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        fpu_req = 1'b0; fpu_rd = '0; fpu_data = '0;
        lsu_req = 1'b0; lsu_rd = '0; lsu_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rs1_used = 1'b1; rs1_index = 5'd0; rs2_used = 1'b1; rs2_index = 5'd31;
        @(negedge clk);
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_hazard", {31'd0, hazard}, 32'd0);
        nxt();
        rst = 1'b0; rs1_used = 1'b0; rs2_used = 1'b0;

        // Single FPU request, then single LSU request
        fpu_req = 1'b1; fpu_rd = 5'd3; fpu_data = 32'h3F800000;
        @(negedge clk);
        chk("t1_fpu_grant", {31'd0, fpu_grant}, 32'd1);
        chk("t1_lsu_grant", {31'd0, lsu_grant}, 32'd0);
        push(5'd3, 32'h3F800000);
        nxt();
        fpu_req = 1'b0;
        lsu_req = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h40000000;
        @(negedge clk);
        chk("t1_lsu_only", {31'd0, lsu_grant}, 32'd1);
        push(5'd2, 32'h40000000);
        nxt();
        lsu_req = 1'b0;

        // Both requesting continuously: FPU, LSU, FPU, LSU
        fpu_req = 1'b1; fpu_rd = 5'd1; fpu_data = 32'h10000000;
        lsu_req = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h20000000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("rr_fpu_grant", {31'd0, fpu_grant}, 32'd1);
                chk("rr_lsu_idle", {31'd0, lsu_grant}, 32'd0);
                push(5'd1, fpu_data);
            end else begin
                chk("rr_lsu_grant", {31'd0, lsu_grant}, 32'd1);
                chk("rr_fpu_idle", {31'd0, fpu_grant}, 32'd0);
                push(5'd2, lsu_data);
            end
            nxt();
            if (k % 2 == 0) fpu_data = fpu_data + 32'd1;
            else            lsu_data = lsu_data + 32'd1;
        end
        fpu_req = 1'b0; lsu_req = 1'b0;

        // RAW hazard on rd=5 until its writeback commits
        issue_valid = 1'b1; issue_rd = 5'd5;
        @(negedge clk);
        chk("issue5_nohaz", {31'd0, hazard}, 32'd0);
        nxt();
        issue_valid = 1'b0; rs1_used = 1'b1; rs1_index = 5'd5;
        @(negedge clk);
        chk("raw_rs1", {31'd0, hazard}, 32'd1);
        nxt();
        rs1_used = 1'b0; rs2_used = 1'b1; rs2_index = 5'd5;
        @(negedge clk);
        chk("raw_rs2", {31'd0, hazard}, 32'd1);
        nxt();
        rs2_index = 5'd6; rs1_index = 5'd5;
        @(negedge clk);
        chk("rs_unused", {31'd0, hazard}, 32'd0);
        nxt();
        rs2_used = 1'b0; rs1_used = 1'b1; rs1_index = 5'd5;
        fpu_req = 1'b1; fpu_rd = 5'd5; fpu_data = 32'hC0A00000;
        @(negedge clk);
        chk("raw5_grant", {31'd0, fpu_grant}, 32'd1);
        chk("raw_grant_cycle", {31'd0, hazard}, 32'd1);
        push(5'd5, 32'hC0A00000);
        nxt();
        fpu_req = 1'b0;
        @(negedge clk);
        chk("raw_commit_cycle", {31'd0, hazard}, 32'd1);
        nxt();
        @(negedge clk);
        chk("raw_cleared", {31'd0, hazard}, 32'd0);
        nxt();
        rs1_used = 1'b0;

        // WAW on rd=7, then issue coinciding with a writeback to 7
        issue_valid = 1'b1; issue_rd = 5'd7;
        @(negedge clk);
        chk("issue7_nohaz", {31'd0, hazard}, 32'd0);
        nxt();
        @(negedge clk);
        chk("waw", {31'd0, hazard}, 32'd1);
        nxt();
        issue_valid = 1'b0;
        lsu_req = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h00000077;
        @(negedge clk);
        chk("wb7_lsu_grant", {31'd0, lsu_grant}, 32'd1);
        push(5'd7, 32'h00000077);
        nxt();
        lsu_req = 1'b0;
        nxt();
        rs1_used = 1'b1; rs1_index = 5'd7;
        @(negedge clk);
        chk("waw_cleared", {31'd0, hazard}, 32'd0);
        nxt();
        rs1_used = 1'b0;
        fpu_req = 1'b1; fpu_rd = 5'd7; fpu_data = 32'h00007070;
        @(negedge clk);
        chk("wb7_fpu_grant", {31'd0, fpu_grant}, 32'd1);
        push(5'd7, 32'h00007070);
        nxt();
        fpu_req = 1'b0; issue_valid = 1'b1; issue_rd = 5'd7;
        @(negedge clk);
        chk("setclr_issue", {31'd0, hazard}, 32'd0);
        nxt();
        issue_valid = 1'b0; rs1_used = 1'b1; rs1_index = 5'd7;
        @(negedge clk);
        chk("set_wins", {31'd0, hazard}, 32'd1);
        nxt();
        rs1_used = 1'b0;

        // Flush with busy 4, 7, 9 and a pending LSU result to 9
        issue_valid = 1'b1; issue_rd = 5'd4;
        nxt();
        issue_rd = 5'd9;
        nxt();
        issue_rd = 5'd4; flush = 1'b1;
        lsu_req = 1'b1; lsu_rd = 5'd9; lsu_data = 32'hDEAD0009;
        @(negedge clk);
        chk("flush_waw4", {31'd0, hazard}, 32'd1);
        chk("flush_lsu_grant", {31'd0, lsu_grant}, 32'd1);
        push(5'd9, 32'hDEAD0009);
        nxt();
        flush = 1'b0; issue_valid = 1'b0; lsu_req = 1'b0;
        rs1_used = 1'b1; rs1_index = 5'd4; rs2_used = 1'b1; rs2_index = 5'd9;
        @(negedge clk);
        chk("flush_clear49", {31'd0, hazard}, 32'd0);
        nxt();
        rs1_index = 5'd7; rs2_used = 1'b0;
        @(negedge clk);
        chk("flush_clear7", {31'd0, hazard}, 32'd0);
        nxt();
        rs1_used = 1'b0; flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd12;
        @(negedge clk);
        chk("flush_issue12", {31'd0, hazard}, 32'd0);
        nxt();
        flush = 1'b0; issue_valid = 1'b0; rs1_used = 1'b1; rs1_index = 5'd12;
        @(negedge clk);
        chk("flush_over_issue", {31'd0, hazard}, 32'd0);
        nxt();
        rs1_used = 1'b0;

        // Async reset mid-arbitration; LSU won last, so FPU wins this conflict
        fpu_req = 1'b1; fpu_rd = 5'd1; fpu_data = 32'hAAAA0001;
        lsu_req = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hBBBB0002;
        @(negedge clk);
        chk("pre_rst_fpu", {31'd0, fpu_grant}, 32'd1);
        nxt();
        chk("pre_rst_wb_en", {31'd0, wb_en}, 32'd1);
        chk("pre_rst_wb_rd", {27'd0, wb_rd}, 32'd1);
        chk("pre_rst_wb_data", wb_data, 32'hAAAA0001);
        #1 rst = 1'b1;
        #1;
        chk("async_wb_en", {31'd0, wb_en}, 32'd0);
        chk("async_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("async_wb_data", wb_data, 32'd0);
        fpu_req = 1'b0; lsu_req = 1'b0;
        nxt();
        rst = 1'b0;
        fpu_req = 1'b1; lsu_req = 1'b1;
        @(negedge clk);
        chk("post_rst_fpu", {31'd0, fpu_grant}, 32'd1);
        chk("post_rst_lsu", {31'd0, lsu_grant}, 32'd0);
        push(5'd1, 32'hAAAA0001);
        nxt();
        fpu_req = 1'b0; lsu_req = 1'b0;
        repeat (3) nxt();

        chk("sb_drain", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
